// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: op codes, FSM states, op-class helpers.
package alu_pkg;

  // Base ops (bit4 = 0)
  localparam logic [4:0] OP_AND    = 5'h00;
  localparam logic [4:0] OP_OR     = 5'h01;
  localparam logic [4:0] OP_SUM    = 5'h02;
  localparam logic [4:0] OP_EQUAL  = 5'h03;
  localparam logic [4:0] OP_SLL    = 5'h04;
  localparam logic [4:0] OP_SRL    = 5'h05;
  localparam logic [4:0] OP_SRA    = 5'h07;
  localparam logic [4:0] OP_XOR    = 5'h08;
  localparam logic [4:0] OP_NOR    = 5'h09;
  localparam logic [4:0] OP_SUB    = 5'h0A;
  localparam logic [4:0] OP_GE     = 5'h0C;
  localparam logic [4:0] OP_GEU    = 5'h0D;
  localparam logic [4:0] OP_SLT    = 5'h0E;
  localparam logic [4:0] OP_SLTU   = 5'h0F;

  // M-extension ops (bit4 = 1)
  localparam logic [4:0] OP_MUL    = 5'h10;
  localparam logic [4:0] OP_MULH   = 5'h11;
  localparam logic [4:0] OP_MULHSU = 5'h12;
  localparam logic [4:0] OP_MULHU  = 5'h13;
  localparam logic [4:0] OP_DIV    = 5'h14;
  localparam logic [4:0] OP_DIVU   = 5'h15;
  localparam logic [4:0] OP_REM    = 5'h16;
  localparam logic [4:0] OP_REMU   = 5'h17;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // True for any M-extension encoding (legal or not)
  function automatic logic is_mext(input logic [4:0] op);
    return op[4];
  endfunction

  // Multiply family 100xx
  function automatic logic is_mul(input logic [4:0] op);
    return is_mext(op) && (op[3:2] == 2'b00);
  endfunction

  // Divide family 101xx
  function automatic logic is_div(input logic [4:0] op);
    return is_mext(op) && (op[3:2] == 2'b01);
  endfunction

endpackage

// File: rtl/alu_base_comb.sv
// Single-cycle base ALU: base op set, illegal-code detection and zero flag.
module alu_base_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  output logic [WIDTH-1:0] rd_c,
  output logic             zr_c,
  output logic             ill_c
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;

  assign shamt = rs2_i[SHW-1:0];

  // Op decode; any M-ext or unassigned code yields RD=0 with ILL set
  always_comb begin
    rd_c  = '0;
    ill_c = 1'b0;
    case (op_i)
      OP_AND:   rd_c = rs1_i & rs2_i;
      OP_OR:    rd_c = rs1_i | rs2_i;
      OP_SUM:   rd_c = rs1_i + rs2_i;
      OP_EQUAL: rd_c = WIDTH'(rs1_i == rs2_i);
      OP_SLL:   rd_c = rs1_i << shamt;
      OP_SRL:   rd_c = rs1_i >> shamt;
      OP_SRA:   rd_c = $unsigned($signed(rs1_i) >>> shamt);
      OP_XOR:   rd_c = rs1_i ^ rs2_i;
      OP_NOR:   rd_c = ~(rs1_i | rs2_i);
      OP_SUB:   rd_c = rs1_i - rs2_i;
      OP_GE:    rd_c = WIDTH'($signed(rs1_i) >= $signed(rs2_i));
      OP_GEU:   rd_c = WIDTH'(rs1_i >= rs2_i);
      OP_SLT:   rd_c = WIDTH'($signed(rs1_i) < $signed(rs2_i));
      OP_SLTU:  rd_c = WIDTH'(rs1_i < rs2_i);
      default:  ill_c = 1'b1;
    endcase
  end

  // Zero flag of the combinational result
  always_comb begin
    zr_c = (rd_c == '0);
  end

endmodule

// File: rtl/alu_iter.sv
// Handshaked execute-stage ALU: 1-cycle base ops, radix-2 iterative multiply,
// optional restoring divide enabled by defining ALU_ITER_DIV_EN.
module alu_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ALU_IN_VALID_i,
  output logic             ALU_IN_READY_o,
  input  logic [4:0]       ALU_OP_i,
  input  logic [WIDTH-1:0] ALU_RS1_i,
  input  logic [WIDTH-1:0] ALU_RS2_i,
  output logic             ALU_OUT_VALID_o,
  input  logic             ALU_OUT_READY_i,
  output logic [WIDTH-1:0] ALU_RD_o,
  output logic             ALU_ZR_o,
  output logic             ALU_ILL_o
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [1:0]       op_lo_q, op_lo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] rd_q, rd_d;
  logic             zr_q, zr_d;
  logic             ill_q, ill_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_c;

  logic [WIDTH-1:0] base_rd_c;
  logic             base_zr_c;
  logic             base_ill_c;

  logic             in_mul, s1, s2, rs1_sgn, rs2_sgn;
  logic [WIDTH-1:0] mag1, mag2;

  logic [W2-1:0]    mul_acc_in, mul_mcand_in, mul_sum, mul_fix;
  logic [WIDTH-1:0] mul_mplier_in, mul_res;

`ifdef ALU_ITER_DIV_EN
  logic             in_div;
  logic             rneg_q, rneg_d;
  logic             div0_q, div0_d;
  logic [W2-1:0]    div_acc_in, div_acc_nxt;
  logic [WIDTH-1:0] div_dvs_in, div_quo, div_rem, div_res;
  logic [WIDTH:0]   div_diff;
`endif

  alu_base_comb #(.WIDTH(WIDTH)) u_base (
    .op_i  (ALU_OP_i),
    .rs1_i (ALU_RS1_i),
    .rs2_i (ALU_RS2_i),
    .rd_c  (base_rd_c),
    .zr_c  (base_zr_c),
    .ill_c (base_ill_c)
  );

  // Classify the offered op and reduce signed operands to sign + magnitude
  always_comb begin
    in_mul  = is_mul(ALU_OP_i);
`ifdef ALU_ITER_DIV_EN
    in_div  = is_div(ALU_OP_i);
`endif
    rs1_sgn = in_mul ? ((ALU_OP_i[1:0] == 2'b01) || (ALU_OP_i[1:0] == 2'b10)) : ~ALU_OP_i[0];
    rs2_sgn = in_mul ? (ALU_OP_i[1:0] == 2'b01) : ~ALU_OP_i[0];
    s1      = rs1_sgn & ALU_RS1_i[WIDTH-1];
    s2      = rs2_sgn & ALU_RS2_i[WIDTH-1];
    mag1    = s1 ? (~ALU_RS1_i + WIDTH'(1)) : ALU_RS1_i;
    mag2    = s2 ? (~ALU_RS2_i + WIDTH'(1)) : ALU_RS2_i;
  end

  // One shift-add step; the accept cycle runs step 0 on the fresh operands
  always_comb begin
    if (state_q == ST_MUL) begin
      mul_acc_in    = acc_q;
      mul_mcand_in  = mcand_q;
      mul_mplier_in = mplier_q;
    end else begin
      mul_acc_in    = '0;
      mul_mcand_in  = {{WIDTH{1'b0}}, mag1};
      mul_mplier_in = mag2;
    end
    mul_sum = mul_acc_in + (mul_mplier_in[0] ? mul_mcand_in : '0);
    mul_fix = neg_q ? (~mul_sum + W2'(1)) : mul_sum;
    mul_res = (op_lo_q == 2'b00) ? mul_fix[WIDTH-1:0] : mul_fix[W2-1:WIDTH];
  end

`ifdef ALU_ITER_DIV_EN
  // One restoring-divide step on {remainder, dividend/quotient}
  always_comb begin
    if (state_q == ST_DIV) begin
      div_acc_in = acc_q;
      div_dvs_in = mcand_q[WIDTH-1:0];
    end else begin
      div_acc_in = {{WIDTH{1'b0}}, mag1};
      div_dvs_in = mag2;
    end
    div_diff = div_acc_in[W2-1:WIDTH-1] - {1'b0, div_dvs_in};
    if (!div_diff[WIDTH]) begin
      div_acc_nxt = {div_diff[WIDTH-1:0], div_acc_in[WIDTH-2:0], 1'b1};
    end else begin
      div_acc_nxt = {div_acc_in[W2-2:0], 1'b0};
    end
    div_quo = div_acc_nxt[WIDTH-1:0];
    div_rem = div_acc_nxt[W2-1:WIDTH];
    // Divide by zero forces an all-ones quotient; the magnitude path already
    // leaves |RS1| as remainder, and MIN/-1 falls out naturally as MIN rem 0.
    if (op_lo_q[1]) begin
      div_res = rneg_q ? (~div_rem + WIDTH'(1)) : div_rem;
    end else if (div0_q) begin
      div_res = '1;
    end else begin
      div_res = neg_q ? (~div_quo + WIDTH'(1)) : div_quo;
    end
  end
`endif

  // FSM next-state, iteration datapath and result register loads
  always_comb begin
    state_d     = state_q;
    op_lo_d     = op_lo_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    neg_d       = neg_q;
    rd_d        = rd_q;
    zr_d        = zr_q;
    ill_d       = ill_q;
    in_ready_c  = 1'b0;
`ifdef ALU_ITER_DIV_EN
    rneg_d      = rneg_q;
    div0_d      = div0_q;
`endif

    case (state_q)
      ST_IDLE: begin
        in_ready_c = 1'b1;
      end
      ST_MUL: begin
        acc_d    = mul_sum;
        mcand_d  = mul_mcand_in << 1;
        mplier_d = mul_mplier_in >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
          rd_d    = mul_res;
          zr_d    = (mul_res == '0);
          ill_d   = 1'b0;
        end
      end
`ifdef ALU_ITER_DIV_EN
      ST_DIV: begin
        acc_d = div_acc_nxt;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
          rd_d    = div_res;
          zr_d    = (div_res == '0);
          ill_d   = 1'b0;
        end
      end
`endif
      ST_DONE: begin
        in_ready_c = ALU_OUT_READY_i;
        if (ALU_OUT_READY_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Accept overrides the retire path so DONE can chain directly into the next op
    if (ALU_IN_VALID_i && in_ready_c) begin
      op_lo_d = ALU_OP_i[1:0];
      neg_d   = s1 ^ s2;
      cnt_d   = '0;
      if (in_mul) begin
        state_d  = ST_MUL;
        acc_d    = mul_sum;
        mcand_d  = mul_mcand_in << 1;
        mplier_d = mul_mplier_in >> 1;
        cnt_d    = CW'(1);
`ifdef ALU_ITER_DIV_EN
      end else if (in_div) begin
        state_d = ST_DIV;
        acc_d   = div_acc_nxt;
        mcand_d = {{WIDTH{1'b0}}, mag2};
        rneg_d  = s1;
        div0_d  = (ALU_RS2_i == '0);
        cnt_d   = CW'(1);
`endif
      end else begin
        state_d = ST_DONE;
        rd_d    = base_rd_c;
        zr_d    = base_zr_c;
        ill_d   = base_ill_c;
      end
    end

    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_lo_q     <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      rd_q        <= '0;
      zr_q        <= 1'b1;
      ill_q       <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ALU_ITER_DIV_EN
      rneg_q      <= 1'b0;
      div0_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_lo_q     <= op_lo_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      neg_q       <= neg_d;
      rd_q        <= rd_d;
      zr_q        <= zr_d;
      ill_q       <= ill_d;
      out_valid_q <= out_valid_d;
`ifdef ALU_ITER_DIV_EN
      rneg_q      <= rneg_d;
      div0_q      <= div0_d;
`endif
    end
  end

  assign ALU_IN_READY_o  = in_ready_c;
  assign ALU_OUT_VALID_o = out_valid_q;
  assign ALU_RD_o        = rd_q;
  assign ALU_ZR_o        = zr_q;
  assign ALU_ILL_o       = ill_q;

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter (WIDTH=32), with a plain-arithmetic reference model.
module tb_alu_iter;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   in_op;
  logic [W-1:0] rs1;
  logic [W-1:0] rs2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] rd_o;
  logic         zr_o;
  logic         ill_o;

  int errs;
  int checks;

  alu_iter #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ALU_IN_VALID_i  (in_valid),
    .ALU_IN_READY_o  (in_ready),
    .ALU_OP_i        (in_op),
    .ALU_RS1_i       (rs1),
    .ALU_RS2_i       (rs2),
    .ALU_OUT_VALID_o (out_valid),
    .ALU_OUT_READY_i (out_ready),
    .ALU_RD_o        (rd_o),
    .ALU_ZR_o        (zr_o),
    .ALU_ILL_o       (ill_o)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference: result and illegal flag straight from the op definitions
  function automatic void model(input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] rd,
                                output logic ill);
    longint sa, sb, ua, ub, p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    rd  = '0;
    ill = 1'b0;
    case (op)
      5'h00: rd = a & b;
      5'h01: rd = a | b;
      5'h02: rd = a + b;
      5'h03: rd = {31'b0, a == b};
      5'h04: rd = a << (b & 32'd31);
      5'h05: rd = a >> (b & 32'd31);
      5'h07: rd = $unsigned($signed(a) >>> (b & 32'd31));
      5'h08: rd = a ^ b;
      5'h09: rd = ~(a | b);
      5'h0A: rd = a - b;
      5'h0C: rd = {31'b0, ia >= ib};
      5'h0D: rd = {31'b0, a >= b};
      5'h0E: rd = {31'b0, ia < ib};
      5'h0F: rd = {31'b0, a < b};
      5'h10: rd = a * b;
      5'h11: begin p = sa * sb; rd = p[63:32]; end
      5'h12: begin p = sa * ub; rd = p[63:32]; end
      5'h13: begin p = ua * ub; rd = p[63:32]; end
`ifdef ALU_ITER_DIV_EN
      5'h14: begin
        if (b == 0) rd = '1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) rd = a;
        else rd = 32'(ia / ib);
      end
      5'h15: rd = (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'h16: begin
        if (b == 0) rd = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) rd = '0;
        else rd = 32'(ia % ib);
      end
      5'h17: rd = (b == 0) ? a : a % b;
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic int exp_latency(input logic [4:0] op);
    if (op[4:2] == 3'b100) return W;
`ifdef ALU_ITER_DIV_EN
    if (op[4:2] == 3'b101) return W;
`endif
    return 1;
  endfunction

  // Offer one op, wait for accept and then for the result; lat counts clock
  // edges from the accept edge (inclusive) until out_valid is seen.
  task automatic xact(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] rd, output logic zr, output logic ill,
                      output int lat, output bit tmo);
    int n;
    tmo = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = op;
    rs1      = a;
    rs2      = b;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) tmo = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rs1      = $urandom;
    rs2      = $urandom;
    in_op    = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) tmo = 1'b1;
    rd  = rd_o;
    zr  = zr_o;
    ill = ill_o;
  endtask

  task automatic test_reset();
    checks++;
    if (out_valid !== 1'b0) begin $display("FAIL reset_valid got=%0b want=0", out_valid); errs++; end
    checks++;
    if (rd_o !== 32'h0) begin $display("FAIL reset_rd got=%h want=0", rd_o); errs++; end
    checks++;
    if (zr_o !== 1'b1) begin $display("FAIL reset_zr got=%0b want=1", zr_o); errs++; end
    checks++;
    if (ill_o !== 1'b0) begin $display("FAIL reset_ill got=%0b want=0", ill_o); errs++; end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin $display("FAIL reset_ready got=%0b want=1", in_ready); errs++; end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  ops [3];
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic [31:0] te [3];
    ops[0] = 5'h02; ta[0] = 32'hFFFF_FFFF; tb[0] = 32'h1;         te[0] = 32'h0;
    ops[1] = 5'h07; ta[1] = 32'h8000_0000; tb[1] = 32'h4;         te[1] = 32'hF800_0000;
    ops[2] = 5'h0F; ta[2] = 32'h1;         tb[2] = 32'hFFFF_FFFF; te[2] = 32'h1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_op = ops[0]; rs1 = ta[0]; rs2 = tb[0];
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin $display("FAIL b2b_ready[%0d] got=%0b want=1", i, in_ready); errs++; end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || rd_o !== te[i]) begin
        $display("FAIL b2b_result[%0d] got valid=%0b rd=%h want valid=1 rd=%h", i, out_valid, rd_o, te[i]);
        errs++;
      end
      if (i == 0) begin
        checks++;
        if (zr_o !== 1'b1) begin $display("FAIL b2b_zr got=%0b want=1", zr_o); errs++; end
      end
      if (i < 2) begin
        in_op = ops[i+1]; rs1 = ta[i+1]; rs2 = tb[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_mul_directed();
    logic [4:0]  ops [3];
    logic [31:0] te [3];
    logic [31:0] rd;
    logic zr, ill;
    int lat;
    bit tmo;
    ops[0] = 5'h11; te[0] = 32'hFFFF_FFFF;
    ops[1] = 5'h13; te[1] = 32'h0000_0001;
    ops[2] = 5'h10; te[2] = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      xact(ops[i], 32'hFFFF_FFFF, 32'h0000_0002, rd, zr, ill, lat, tmo);
      checks++;
      if (tmo || rd !== te[i] || ill !== 1'b0) begin
        $display("FAIL mul_rd op=%h got rd=%h ill=%0b tmo=%0b want rd=%h ill=0", ops[i], rd, ill, tmo, te[i]);
        errs++;
      end
      checks++;
      if (lat != W) begin $display("FAIL mul_latency op=%h got=%0d want=%0d", ops[i], lat, W); errs++; end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, c, d, er, ex;
    logic ei, xi;
    int n;
    a = $urandom; b = $urandom; c = $urandom; d = $urandom;
    model(5'h00, a, b, er, ei);
    model(5'h08, c, d, ex, xi);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 5'h00; rs1 = a; rs2 = b;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    in_op = 5'h08; rs1 = c; rs2 = d;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1) begin $display("FAIL bp_valid[%0d] got=%0b want=1", i, out_valid); errs++; end
      checks++;
      if (rd_o !== er) begin $display("FAIL bp_rd[%0d] got=%h want=%h", i, rd_o, er); errs++; end
      checks++;
      if (zr_o !== (er == 0)) begin $display("FAIL bp_zr[%0d] got=%0b want=%0b", i, zr_o, er == 0); errs++; end
      checks++;
      if (in_ready !== 1'b0) begin $display("FAIL bp_ready[%0d] got=%0b want=0", i, in_ready); errs++; end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin $display("FAIL bp_release_ready got=%0b want=1", in_ready); errs++; end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || rd_o !== ex || ill_o !== 1'b0) begin
      $display("FAIL bp_next_xor got valid=%0b rd=%h ill=%0b want valid=1 rd=%h ill=0", out_valid, rd_o, ill_o, ex);
      errs++;
    end
  endtask

  task automatic test_illegal();
    logic [31:0] rd;
    logic zr, ill;
    int lat;
    bit tmo;
    xact(5'h06, 32'h1234_5678, 32'h9ABC_DEF0, rd, zr, ill, lat, tmo);
    checks++;
    if (tmo || rd !== 32'h0 || zr !== 1'b1 || ill !== 1'b1 || lat != 1) begin
      $display("FAIL illegal_06 got rd=%h zr=%0b ill=%0b lat=%0d want rd=0 zr=1 ill=1 lat=1", rd, zr, ill, lat);
      errs++;
    end
    xact(5'h1B, 32'h5, 32'h3, rd, zr, ill, lat, tmo);
    checks++;
    if (tmo || rd !== 32'h0 || ill !== 1'b1 || lat != 1) begin
      $display("FAIL illegal_1B got rd=%h ill=%0b lat=%0d want rd=0 ill=1 lat=1", rd, ill, lat);
      errs++;
    end
    xact(5'h14, 32'd7, 32'd2, rd, zr, ill, lat, tmo);
    checks++;
`ifdef ALU_ITER_DIV_EN
    if (tmo || rd !== 32'd3 || ill !== 1'b0 || lat != W) begin
      $display("FAIL div_7_2 got rd=%h ill=%0b lat=%0d want rd=3 ill=0 lat=%0d", rd, ill, lat, W);
      errs++;
    end
`else
    if (tmo || rd !== 32'h0 || ill !== 1'b1 || lat != 1) begin
      $display("FAIL div_disabled got rd=%h ill=%0b lat=%0d want rd=0 ill=1 lat=1", rd, ill, lat);
      errs++;
    end
`endif
  endtask

`ifdef ALU_ITER_DIV_EN
  task automatic test_div();
    logic [4:0]  ops [4];
    logic [31:0] ta [4];
    logic [31:0] tb [4];
    logic [31:0] te [4];
    logic [31:0] rd;
    logic zr, ill;
    int lat;
    bit tmo;
    ops[0] = 5'h14; ta[0] = 32'h8000_0000; tb[0] = 32'hFFFF_FFFF; te[0] = 32'h8000_0000;
    ops[1] = 5'h16; ta[1] = 32'hFFFF_FFF9; tb[1] = 32'h2;         te[1] = 32'hFFFF_FFFF;
    ops[2] = 5'h15; ta[2] = 32'h5;         tb[2] = 32'h0;         te[2] = 32'hFFFF_FFFF;
    ops[3] = 5'h17; ta[3] = 32'h5;         tb[3] = 32'h0;         te[3] = 32'h5;
    for (int i = 0; i < 4; i++) begin
      xact(ops[i], ta[i], tb[i], rd, zr, ill, lat, tmo);
      checks++;
      if (tmo || rd !== te[i] || lat != W) begin
        $display("FAIL div_directed[%0d] got rd=%h lat=%0d tmo=%0b want rd=%h lat=%0d", i, rd, lat, tmo, te[i], W);
        errs++;
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] spec [5];
    logic [31:0] a, b, rd, er;
    logic [4:0] op;
    logic zr, ill, ei;
    int lat;
    bit tmo;
    spec[0] = 32'h0; spec[1] = 32'h1; spec[2] = 32'hFFFF_FFFF;
    spec[3] = 32'h8000_0000; spec[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 48; i++) begin
      op = 5'($urandom_range(0, 31));
      a  = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? spec[$urandom_range(0, 4)] : $urandom;
      model(op, a, b, er, ei);
      xact(op, a, b, rd, zr, ill, lat, tmo);
      checks++;
      if (tmo) begin $display("FAIL rand_timeout[%0d] op=%h", i, op); errs++; end
      checks++;
      if (rd !== er) begin $display("FAIL rand_rd[%0d] op=%h a=%h b=%h got=%h want=%h", i, op, a, b, rd, er); errs++; end
      checks++;
      if (zr !== (er == 0) || ill !== ei) begin
        $display("FAIL rand_flags[%0d] op=%h got zr=%0b ill=%0b want zr=%0b ill=%0b", i, op, zr, ill, er == 0, ei);
        errs++;
      end
      checks++;
      if (lat != exp_latency(op)) begin
        $display("FAIL rand_latency[%0d] op=%h got=%0d want=%0d", i, op, lat, exp_latency(op));
        errs++;
      end
    end
  endtask

  task automatic test_reset_mid_mul();
    int stale;
    logic [31:0] rd, er;
    logic zr, ill, ei;
    int lat;
    bit tmo;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_op = 5'h10; rs1 = 32'h0001_2345; rs2 = 32'h0000_0777;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || rd_o !== 32'h0 || zr_o !== 1'b1) begin
      $display("FAIL rst_mid_mul got valid=%0b rd=%h zr=%0b want valid=0 rd=0 zr=1", out_valid, rd_o, zr_o);
      errs++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin $display("FAIL rst_mid_ready got=%0b want=1", in_ready); errs++; end
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin $display("FAIL rst_stale_result got=%0d valid cycles want=0", stale); errs++; end
    model(5'h13, 32'hDEAD_BEEF, 32'hCAFE_F00D, er, ei);
    xact(5'h13, 32'hDEAD_BEEF, 32'hCAFE_F00D, rd, zr, ill, lat, tmo);
    checks++;
    if (tmo || rd !== er || lat != W) begin
      $display("FAIL rst_recover got rd=%h lat=%0d want rd=%h lat=%0d", rd, lat, er, W);
      errs++;
    end
  endtask

  initial begin
    errs      = 0;
    checks    = 0;
    clk       = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    rs1       = '0;
    rs2       = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_back_to_back();
    test_mul_directed();
    test_backpressure();
    test_illegal();
`ifdef ALU_ITER_DIV_EN
    test_div();
`endif
    test_random();
    test_reset_mid_mul();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised, handshaked successor to the processor's combinational ALU.
- Executes the existing 4-bit ALU op set in one cycle, plus RV32M-style multiply ops iteratively (radix-2, one bit per cycle). Divide ops are optional.
- Sits between issue/decode and writeback in the execute stage.
- Result and flags are registered and held until writeback accepts them.

Parameters:
WIDTH, 32, operand/result width; must be a power of two, at least 8. Shift amount is RS2[SHW-1:0] with SHW = $clog2(WIDTH).

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
ALU_IN_VALID_i  in  1  operation offered
ALU_IN_READY_o  out  1  operation accepted on this cycle when valid&ready
ALU_OP_i  in  5  bit4=0: base op (codes below); bit4=1: M-ext op
ALU_RS1_i  in  WIDTH  operand 1
ALU_RS2_i  in  WIDTH  operand 2
ALU_OUT_VALID_o  out  1  result valid
ALU_OUT_READY_i  in  1  consumer takes result when valid&ready
ALU_RD_o  out  WIDTH  result
ALU_ZR_o  out  1  ALU_RD_o == 0
ALU_ILL_o  out  1  op was unsupported/illegal

Behaviour:
- Base ops, ALU_OP_i[3:0] with bit4=0:
  - AND 0000, OR 0001, SUM 0010, EQUAL 0011, SLL 0100, SRL 0101, SRA 0111, XOR 1000, NOR 1001, SUB 1010, GE 1100, GEU 1101, SLT 1110, SLTU 1111.
  - Compare ops return 0 or 1, zero-extended. Add/sub wrap modulo 2^WIDTH.
- M ops, bit4=1: MUL 10000 (low half), MULH 10001 (s×s high), MULHSU 10010 (s×u high), MULHU 10011 (u×u high). DIV 10100, DIVU 10101, REM 10110, REMU 10111 only with the optional feature.
- Illegal op (0x06, 0x0B, 11xxx, or div ops when the feature is off): completes as a base op with RD=0, ZR=1, ILL=1.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: ready=1. On accept, operands and op are captured. Base/illegal ops go to DONE. Mul ops go to MUL. Div ops go to DIV.
  - MUL/DIV: ready=0. Counter runs 0..WIDTH-1, one iteration per edge. The last iteration applies the sign fix-up and loads the result, then the FSM goes to DONE.
  - DONE: out_valid=1. RD/ZR/ILL are held stable while out_ready=0. When out_ready=1 the result retires. If a new valid op is present in that same cycle it is accepted (ready = out_ready in DONE) and the FSM goes straight to its next state; otherwise it returns to IDLE.
- Latency, counted from the accept edge N:
  - Base ops: out_valid high after N+1.
  - MUL/DIV: out_valid high after N+WIDTH.
  - Base-op throughput is 1 per cycle when out_ready is held high.
- Multiply:
  - Signed operands are converted to magnitude and a sign bit.
  - A 2·WIDTH product is built by shift-add.
  - The product is negated if the signs differ.
  - High ops return product[2W-1:W]; MUL returns product[W-1:0].
- Operands are not sampled after accept; changes on RS1/RS2 mid-operation have no effect.
- Reset (async, any state, mid-iteration included): state=IDLE, ALU_OUT_VALID_o=0, ALU_RD_o=0, ALU_ZR_o=1, ALU_ILL_o=0, counter=0. ALU_IN_READY_o=1 once reset is released. An in-flight operation is discarded.
- in_valid with ready=0 is ignored; the producer must hold the op.

Optional Feature:
- Macro ALU_ITER_DIV_EN.
- Defined: restoring divider on the DIV path, WIDTH iterations with the same latency as MUL.
  - Divide by zero: quotient = all ones, remainder = RS1.
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
  - Signed results use truncating division; the remainder takes the sign of the dividend.
- Undefined: the DIV state and datapath are absent; ops 101xx are illegal (1-cycle, ILL=1).

Decomposition:
- Shared package alu_pkg:
  - op-code localparams (5-bit, base codes zero-extended);
  - FSM state encoding;
  - helper function is_mext(op).
- One natural sub-module: alu_base_comb. It is purely combinational: the base op set at WIDTH, illegal detection for base codes, and zero flag. It is reused by the top for the 1-cycle path. The iterative mul/div datapath stays in the top.

Test Plan:
- Reset mid-MUL: assert rst_n=0 at iteration 10 → out_valid=0 and RD=0 immediately; ready=1 after release; no stale result appears.
- Back-to-back base ops, out_ready=1, WIDTH=32: SUM 0xFFFFFFFF+1 → RD=0, ZR=1; then SRA 0x80000000>>4 → 0xF8000000; then SLTU 1<0xFFFFFFFF → 1. One result per cycle, latency 1.
- MULH 0xFFFFFFFF×0x00000002 → RD=0xFFFFFFFF; MULHU same operands → 0x00000001; MUL → 0xFFFFFFFE. out_valid exactly 32 cycles after accept.
- Backpressure: out_ready=0 for 5 cycles in DONE → RD/ZR/out_valid stable and ready=0. Then out_ready=1 with a new XOR op offered in the same cycle → accepted with no bubble.
- Illegal op 0x06 → RD=0, ZR=1, ILL=1, latency 1. Without ALU_ITER_DIV_EN, DIV 7/2 → ILL=1, 1 cycle.
- With ALU_ITER_DIV_EN:
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM −7/2 → 0xFFFFFFFF.
  - DIVU 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - Each takes 32 cycles.
